// File: rtl/seg_scan_controller.sv
// Multi-digit seven-segment scan controller.
// Time-multiplexes NUM_DIGITS BCD digits onto one shared decoder. It inserts a
// guard gap between digits, blanks leading zeros and takes new values through
// a one-deep valid/ready buffer. New values are committed only at frame
// boundaries, so a frame never shows a mix of old and new digits.
module seg_scan_controller #(
    parameter int NUM_DIGITS = 4,
    parameter int SHOW_CYC   = 100000,
    parameter int GUARD_CYC  = 1000,
    parameter int CNT_W      = 17
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      blank_lz,
    input  logic                      load_valid,
    input  logic [4*NUM_DIGITS-1:0]   load_value,
    output logic                      load_ready,
    output logic [3:0]                dec_code,
    output logic [NUM_DIGITS-1:0]     digit_en_n,
    output logic                      frame_tick
);

    localparam int                IDX_W     = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]  SHOW_END  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0]  GUARD_END = CNT_W'(GUARD_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_GUARD
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          timer_q, timer_d;
    logic [4*NUM_DIGITS-1:0]   active_q, active_d;
    logic [4*NUM_DIGITS-1:0]   pending_q, pending_d;
    logic                      pending_full_q, pending_full_d;
    logic                      committed_q, committed_d;
    logic                      load_ready_q, load_ready_d;
    logic [3:0]                dec_code_q, dec_code_d;
    logic [NUM_DIGITS-1:0]     digit_en_n_q, digit_en_n_d;
    logic                      frame_tick_q, frame_tick_d;
    logic                      blanked;

    // Load buffer, commit and scan sequencing (next-state logic).
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        committed_d    = committed_q;

        // load_ready_q mirrors !pending_full_q, so transfer and commit are
        // mutually exclusive in any one cycle.
        if (load_valid && load_ready_q) begin
            pending_d      = load_value;
            pending_full_d = 1'b1;
        end else if (pending_full_q && (state_q == ST_OFF || frame_tick_q)) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
            committed_d    = 1'b1;
        end

        if (!enable) begin
            state_d = ST_OFF;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (committed_q) begin
                        state_d = ST_SHOW;
                        idx_d   = '0;
                        timer_d = '0;
                    end
                end
                ST_SHOW: begin
                    if (timer_q == SHOW_END) begin
                        state_d = ST_GUARD;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_GUARD: begin
                    if (timer_q == GUARD_END) begin
                        state_d = ST_SHOW;
                        timer_d = '0;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    idx_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // A digit is blanked when it and every higher digit of the value being shown are zero.
    always_comb begin
        blanked = 1'b0;
        if (blank_lz && idx_d != '0) begin
            blanked = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (IDX_W'(i) >= idx_d && active_d[4*i +: 4] != 4'd0) begin
                    blanked = 1'b0;
                end
            end
        end
    end

    // Output values for the next cycle, so code and enable switch on the same edge.
    always_comb begin
        digit_en_n_d = '1;
        dec_code_d   = '0;
        load_ready_d = !pending_full_d;
        frame_tick_d = (state_d == ST_GUARD) && (timer_d == GUARD_END) &&
                       (idx_d == LAST_IDX);
        if (state_d == ST_SHOW && !blanked) begin
            digit_en_n_d[idx_d] = 1'b0;
            dec_code_d          = active_d[4*idx_d +: 4];
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q        <= ST_OFF;
            idx_q          <= '0;
            timer_q        <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            committed_q    <= 1'b0;
            load_ready_q   <= 1'b1;
            dec_code_q     <= '0;
            digit_en_n_q   <= '1;
            frame_tick_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            committed_q    <= committed_d;
            load_ready_q   <= load_ready_d;
            dec_code_q     <= dec_code_d;
            digit_en_n_q   <= digit_en_n_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    assign load_ready = load_ready_q;
    assign dec_code   = dec_code_q;
    assign digit_en_n = digit_en_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed testbench for seg_scan_controller with 4 digits, 4 show cycles and
// 1 guard cycle, which gives a 20-cycle frame. Slot k of a frame is digit k/5,
// phase k%5. Phases 0..3 are lit and phase 4 is the guard gap.
module tb_seg_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        blank_lz;
    logic        load_valid;
    logic [15:0] load_value;
    logic        load_ready;
    logic [3:0]  dec_code;
    logic [3:0]  digit_en_n;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    seg_scan_controller #(
        .NUM_DIGITS(4),
        .SHOW_CYC  (4),
        .GUARD_CYC (1),
        .CNT_W     (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .blank_lz  (blank_lz),
        .load_valid(load_valid),
        .load_value(load_value),
        .load_ready(load_ready),
        .dec_code  (dec_code),
        .digit_en_n(digit_en_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // No more than one digit may be enabled at any time.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(~digit_en_n) > 1) begin
                errors++;
                $display("FAIL onehot: digit_en_n=%b has more than one low bit", digit_en_n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_first_load();
        logic [15:0] cur;
        logic [3:0]  exp_en;
        int s, c;
        rst_n = 1'b0; enable = 1'b0; blank_lz = 1'b0;
        load_valid = 1'b0; load_value = 16'h0000;
        repeat (3) tick();
        checks++;
        if (digit_en_n !== 4'b1111 || load_ready !== 1'b1 || frame_tick !== 1'b0 || dec_code !== 4'h0) begin
            errors++;
            $display("FAIL reset: en=%b ready=%b tick=%b code=%h want 1111 1 0 0", digit_en_n, load_ready, frame_tick, dec_code);
        end
        rst_n = 1'b1; enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (digit_en_n !== 4'b1111 || load_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_off j%0d: en=%b ready=%b want 1111 1", j, digit_en_n, load_ready);
            end
        end
        load_valid = 1'b1; load_value = 16'h1234;
        tick();
        load_valid = 1'b0;
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_xfer: ready=%b want 0", load_ready);
        end
        tick();
        checks++;
        if (load_ready !== 1'b1 || digit_en_n !== 4'b1111) begin
            errors++;
            $display("FAIL first_commit: ready=%b en=%b want 1 1111", load_ready, digit_en_n);
        end
        cur = 16'h1234;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 20; k++) begin
                tick();
                s = k / 5; c = k % 5;
                exp_en = (c < 4) ? ~(4'b0001 << s) : 4'b1111;
                checks++;
                if (digit_en_n !== exp_en) begin
                    errors++;
                    $display("FAIL first_en f%0d k%0d: got %b want %b", f, k, digit_en_n, exp_en);
                end
                if (c < 4) begin
                    checks++;
                    if (dec_code !== cur[4*s +: 4]) begin
                        errors++;
                        $display("FAIL first_code f%0d k%0d: got %h want %h", f, k, dec_code, cur[4*s +: 4]);
                    end
                end
                checks++;
                if (frame_tick !== (k == 19)) begin
                    errors++;
                    $display("FAIL first_tick f%0d k%0d: got %b", f, k, frame_tick);
                end
            end
        end
    endtask

    task automatic test_tear_free();
        logic [15:0] vals [0:1];
        logic [15:0] cur;
        logic [3:0]  exp_en;
        int s, c;
        vals[0] = 16'h1234; vals[1] = 16'h5678;
        for (int f = 0; f < 2; f++) begin
            cur = vals[f];
            for (int k = 0; k < 20; k++) begin
                tick();
                s = k / 5; c = k % 5;
                exp_en = (c < 4) ? ~(4'b0001 << s) : 4'b1111;
                checks++;
                if (digit_en_n !== exp_en) begin
                    errors++;
                    $display("FAIL tear_en f%0d k%0d: got %b want %b", f, k, digit_en_n, exp_en);
                end
                if (c < 4) begin
                    checks++;
                    if (dec_code !== cur[4*s +: 4]) begin
                        errors++;
                        $display("FAIL tear_code f%0d k%0d: got %h want %h", f, k, dec_code, cur[4*s +: 4]);
                    end
                end
                checks++;
                if (frame_tick !== (k == 19)) begin
                    errors++;
                    $display("FAIL tear_tick f%0d k%0d: got %b", f, k, frame_tick);
                end
                if ((f == 0 && k >= 7) || (f == 1 && k == 0)) begin
                    checks++;
                    if (load_ready !== (f == 1)) begin
                        errors++;
                        $display("FAIL tear_ready f%0d k%0d: got %b want %b", f, k, load_ready, (f == 1));
                    end
                end
                if (f == 0 && k == 6) begin
                    load_valid = 1'b1; load_value = 16'h5678;
                end
                if (f == 0 && k == 7) load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] vals [0:2];
        logic [15:0] cur;
        logic [3:0]  exp_en;
        int s, c;
        vals[0] = 16'h5678; vals[1] = 16'h9abc; vals[2] = 16'h4321;
        for (int f = 0; f < 3; f++) begin
            cur = vals[f];
            for (int k = 0; k < 20; k++) begin
                tick();
                s = k / 5; c = k % 5;
                exp_en = (c < 4) ? ~(4'b0001 << s) : 4'b1111;
                checks++;
                if (digit_en_n !== exp_en) begin
                    errors++;
                    $display("FAIL bp_en f%0d k%0d: got %b want %b", f, k, digit_en_n, exp_en);
                end
                if (c < 4) begin
                    checks++;
                    if (dec_code !== cur[4*s +: 4]) begin
                        errors++;
                        $display("FAIL bp_code f%0d k%0d: got %h want %h", f, k, dec_code, cur[4*s +: 4]);
                    end
                end
                checks++;
                if (frame_tick !== (k == 19)) begin
                    errors++;
                    $display("FAIL bp_tick f%0d k%0d: got %b", f, k, frame_tick);
                end
                if (f < 2 || k == 0) begin
                    checks++;
                    if (load_ready !== (k == 0)) begin
                        errors++;
                        $display("FAIL bp_ready f%0d k%0d: got %b want %b", f, k, load_ready, (k == 0));
                    end
                end
                if (f == 0 && k == 0) begin
                    load_valid = 1'b1; load_value = 16'h9abc;
                end
                if (f == 0 && k == 1) load_value = 16'h4321;
                if (f == 1 && k == 1) load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] vals [0:2];
        logic [3:0]  lits [0:2];
        logic [15:0] cur;
        logic [3:0]  lit;
        logic [3:0]  exp_en;
        int s, c;
        vals[0] = 16'h4321; vals[1] = 16'h0050; vals[2] = 16'h0000;
        lits[0] = 4'b1111;  lits[1] = 4'b0011;  lits[2] = 4'b0001;
        blank_lz = 1'b1;
        for (int f = 0; f < 3; f++) begin
            cur = vals[f];
            lit = lits[f];
            for (int k = 0; k < 20; k++) begin
                tick();
                s = k / 5; c = k % 5;
                exp_en = (c < 4 && lit[s]) ? ~(4'b0001 << s) : 4'b1111;
                checks++;
                if (digit_en_n !== exp_en) begin
                    errors++;
                    $display("FAIL blank_en f%0d k%0d: got %b want %b", f, k, digit_en_n, exp_en);
                end
                if (exp_en != 4'b1111) begin
                    checks++;
                    if (dec_code !== cur[4*s +: 4]) begin
                        errors++;
                        $display("FAIL blank_code f%0d k%0d: got %h want %h", f, k, dec_code, cur[4*s +: 4]);
                    end
                end
                checks++;
                if (frame_tick !== (k == 19)) begin
                    errors++;
                    $display("FAIL blank_tick f%0d k%0d: got %b", f, k, frame_tick);
                end
                if (f < 2 && k == 0) begin
                    load_valid = 1'b1;
                    load_value = (f == 0) ? 16'h0050 : 16'h0000;
                end
                if (k == 1) load_valid = 1'b0;
            end
        end
    endtask

    task automatic test_enable_reset();
        logic [15:0] vals [0:1];
        logic [15:0] cur;
        logic [3:0]  exp_en;
        int s, c;
        vals[0] = 16'h0000; vals[1] = 16'h1234;
        blank_lz = 1'b0;
        for (int f = 0; f < 2; f++) begin
            cur = vals[f];
            for (int k = 0; k < 20; k++) begin
                if (f == 1 && k == 12) break;
                tick();
                s = k / 5; c = k % 5;
                exp_en = (c < 4) ? ~(4'b0001 << s) : 4'b1111;
                checks++;
                if (digit_en_n !== exp_en || (c < 4 && dec_code !== cur[4*s +: 4])) begin
                    errors++;
                    $display("FAIL en_scan f%0d k%0d: en=%b code=%h want %b %h", f, k, digit_en_n, dec_code, exp_en, cur[4*s +: 4]);
                end
                if (f == 0 && k == 0) begin
                    load_valid = 1'b1; load_value = 16'h1234;
                end
                if (k == 1) load_valid = 1'b0;
            end
        end
        // Currently in the SHOW slot of digit 2.
        enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if (digit_en_n !== 4'b1111 || frame_tick !== 1'b0 || load_ready !== 1'b1) begin
                errors++;
                $display("FAIL en_off j%0d: en=%b tick=%b ready=%b want 1111 0 1", j, digit_en_n, frame_tick, load_ready);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            tick();
            checks++;
            if (digit_en_n !== ((j < 4) ? 4'b1110 : 4'b1111) || (j < 4 && dec_code !== 4'h4)) begin
                errors++;
                $display("FAIL en_restart j%0d: en=%b code=%h want digit 0 code 4", j, digit_en_n, dec_code);
            end
        end
        // Now in the guard gap after digit 0.
        rst_n = 1'b0;
        tick();
        checks++;
        if (digit_en_n !== 4'b1111 || load_ready !== 1'b1 || frame_tick !== 1'b0 || dec_code !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset: en=%b ready=%b tick=%b code=%h want 1111 1 0 0", digit_en_n, load_ready, frame_tick, dec_code);
        end
        rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            tick();
            checks++;
            if (digit_en_n !== 4'b1111) begin
                errors++;
                $display("FAIL post_reset_off j%0d: en=%b want 1111", j, digit_en_n);
            end
        end
    endtask

    initial begin
        test_reset_first_load();
        test_tear_free();
        test_back_pressure();
        test_blanking();
        test_enable_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
